// File: rtl/imm_narrower.sv
// Narrows a wide two's-complement value to an OUT_W-bit immediate (saturate or wrap per item)
// behind a 2-entry in-order output buffer, and counts non-fitting accepts.
module imm_narrower #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_fits,
  input  logic             ovf_clr,
  output logic [7:0]       ovf_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   head_data_q, head_data_d;
  logic               head_fits_q, head_fits_d;
  logic [OUT_W-1:0]   tail_data_q, tail_data_d;
  logic               tail_fits_q, tail_fits_d;
  logic [7:0]         ovf_q, ovf_d;

  logic               accept;
  logic               xfer;
  logic [IN_W-OUT_W:0] upper;
  logic               fits;
  logic [OUT_W-1:0]   sat_val;
  logic [OUT_W-1:0]   new_data;

  // Bits above the immediate's sign bit must all copy it for an exact fit.
  assign upper   = in_data[IN_W-1:OUT_W-1];
  assign fits    = (&upper) | ~(|upper);
  assign sat_val = {in_data[IN_W-1], {(OUT_W-1){~in_data[IN_W-1]}}};

  always_comb begin
    new_data = in_data[OUT_W-1:0];
    if (!fits && in_sat) begin
      new_data = sat_val;
    end
  end

  // rst gating keeps an accept offered during the reset cycle from being seen.
  assign in_ready  = in_ready_q & ~rst;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_fits_d = head_fits_q;
    tail_data_d = tail_data_q;
    tail_fits_d = tail_fits_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_data_d = new_data;
          head_fits_d = fits;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (accept && xfer) begin
          head_data_d = new_data;
          head_fits_d = fits;
        end else if (accept) begin
          tail_data_d = new_data;
          tail_fits_d = fits;
          state_d     = StTwo;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (xfer) begin
          head_data_d = tail_data_q;
          head_fits_d = tail_fits_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    out_valid_d = (state_d != StEmpty);
    in_ready_d  = (state_d != StTwo);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = (accept && !fits) ? 8'd1 : 8'd0;
    end else if (accept && !fits && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_data_q <= '0;
      head_fits_q <= 1'b0;
      tail_data_q <= '0;
      tail_fits_q <= 1'b0;
      ovf_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_data_q <= head_data_d;
      head_fits_q <= head_fits_d;
      tail_data_q <= tail_data_d;
      tail_fits_q <= tail_fits_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = head_data_q;
  assign out_fits  = head_fits_q;
  assign ovf_count = ovf_q;

endmodule

// File: tb/tb_imm_narrower.sv
// Scoreboard bench for imm_narrower: expected results queued at accept, compared at transfer.
module tb_imm_narrower;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_fits;
  logic             ovf_clr;
  logic [7:0]       ovf_count;

  imm_narrower #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_fits  (out_fits),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [OUT_W:0] exp_q[$];
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic             prev_fits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed range test, then saturate or keep the low bits.
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d, input logic s);
    int v  = int'($signed(d));
    int lo = -(1 << (OUT_W - 1));
    int hi = (1 << (OUT_W - 1)) - 1;
    logic [OUT_W-1:0] lowb = d[OUT_W-1:0];
    if (v >= lo && v <= hi) return {lowb, 1'b1};
    if (!s) return {lowb, 1'b0};
    if (v > hi) return {OUT_W'(hi), 1'b0};
    return {OUT_W'(lo), 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_fits", 32'(out_fits), 32'(prev_fits));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          logic [OUT_W:0] e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[OUT_W:1]));
          check("out_fits", 32'(out_fits), 32'(e[0]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_fits  = out_fits;
    end
  end

  // Offers one item, pushes its expectation when accepted, returns at posedge+1 after accept.
  task automatic send(input logic [IN_W-1:0] d, input logic s, input logic [OUT_W:0] e);
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sat   = s;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    check("accept_in_time", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = IN_W'($urandom);
    in_sat   = 1'($urandom);
  endtask

  task automatic send_m(input logic [IN_W-1:0] d, input logic s);
    send(d, s, model(d, s));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sat = 1'b0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_fits", 32'(out_fits), 32'd0);
    check("rst_ovf", 32'(ovf_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed narrowing cases with literal expectations.
    send(16'h0008, 1'b1, {4'b0111, 1'b0});
    check("latency1_valid", 32'(out_valid), 32'd1);
    check("ovf_after_first", 32'(ovf_count), 32'd1);
    send(16'h0008, 1'b0, {4'b1000, 1'b0});
    send(16'hFFF8, 1'b1, {4'b1000, 1'b1});
    send(16'h0007, 1'b0, {4'b0111, 1'b1});
    send(16'h8000, 1'b1, {4'b1000, 1'b0});
    send(16'h7FFF, 1'b1, {4'b0111, 1'b0});
    send(16'hFFF7, 1'b0, {4'b0111, 1'b0});
    drain();
    check("ovf_directed", 32'(ovf_count), 32'd5);

    // Backpressure: two accepts fill the buffer, third waits.
    out_ready = 1'b0;
    send_m(16'h0003, 1'b0);
    send_m(16'h0123, 1'b1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    done = 1'b0;
    fork
      send_m(16'hFF00, 1'b0);
      begin
        cycles(5);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random stream with random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [IN_W-1:0] d;
          d = (i % 2 == 0) ? IN_W'($urandom) : IN_W'($signed($urandom_range(0, 20)) - 10);
          send_m(d, 1'($urandom));
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    drain();

    // Continuous streaming: one result per cycle, buffer stays at one entry.
    for (int i = 0; i < 12; i++) begin
      send_m(IN_W'(i * 37 - 200), 1'(i));
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_ready", 32'(in_ready), 32'd1);
    end
    drain();

    // Overflow counter saturation and clear.
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    check("ovf_clr_alone", 32'(ovf_count), 32'd0);
    for (int i = 0; i < 300; i++) send_m(IN_W'(16'h0100 + i), 1'($urandom));
    check("ovf_saturated", 32'(ovf_count), 32'd255);
    ovf_clr = 1'b1;
    send_m(16'h4000, 1'b1);
    ovf_clr = 1'b0;
    check("ovf_clr_with_accept", 32'(ovf_count), 32'd1);
    drain();

    // Reset while full; an offer during reset must be ignored.
    out_ready = 1'b0;
    send_m(16'h0200, 1'b1);
    send_m(16'h0001, 1'b0);
    check("two_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h0555; in_sat = 1'b1;
    @(negedge clk);
    check("rst_cycle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_two_out_valid", 32'(out_valid), 32'd0);
    check("rst_two_ovf", 32'(ovf_count), 32'd0);
    out_ready = 1'b1;
    cycles(6);
    check("no_stale_valid", 32'(out_valid), 32'd0);
    send_m(16'hFFFE, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_narrower.md
IMM_NARROWER -- requirements
Module: imm_narrower

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning the width of the wide input value.
REQ-002 SHALL have parameter OUT_W, default 4, meaning the width of the narrow immediate; legal range 2..IN_W-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising clk edge.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data and in_sat are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts input this cycle.
REQ-007 SHALL have port in_data, input, IN_W, the two's-complement value to narrow.
REQ-008 SHALL have port in_sat, input, 1, per-item mode: 1 selects saturate, 0 selects wrap.
REQ-009 SHALL have port out_valid, output, 1, meaning the head result is presented.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the head result this cycle.
REQ-011 SHALL have port out_data, output, OUT_W, the narrowed immediate.
REQ-012 SHALL have port out_fits, output, 1, meaning in_data was exactly representable in OUT_W signed bits.
REQ-013 SHALL have port ovf_clr, input, 1, synchronous clear of ovf_count.
REQ-014 SHALL have port ovf_count, output, 8, the saturating count of accepted non-fitting items.

Function
REQ-015 SHALL treat input accept as in_valid && in_ready and output transfer as out_valid && out_ready.
REQ-016 SHALL compute fits = 1 iff in_data[IN_W-1:OUT_W-1] are all equal (sign-extension of OUT_W bits reproduces in_data).
REQ-017 SHALL, when fits, output out_data = in_data[OUT_W-1:0] regardless of in_sat.
REQ-018 SHALL, when not fits and in_sat=1, output max positive (0 then all ones, 4'b0111) if in_data[IN_W-1]=0, else min negative (1 then all zeros, 4'b1000).
REQ-019 SHALL, when not fits and in_sat=0, output in_data[OUT_W-1:0] (wrap).
REQ-020 SHALL register results in a 2-entry in-order output buffer, FSM states EMPTY, ONE, TWO.
REQ-021 SHALL present an accepted item on out_valid exactly 1 cycle after the accept edge (latency 1) when the buffer was EMPTY.
REQ-022 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO; in_ready SHALL be a register output, with no combinational path from out_ready.
REQ-023 SHALL transition EMPTY->ONE on accept; ONE->TWO on accept without transfer; ONE->EMPTY on transfer without accept; stay ONE on simultaneous accept and transfer; TWO->ONE on transfer.
REQ-024 SHALL hold out_data and out_fits stable while out_valid=1 and out_ready=0.
REQ-025 SHALL never drop, duplicate or reorder items.
REQ-026 SHALL increment ovf_count by 1 on each accept with fits=0, saturating at 255.
REQ-027 SHALL, on ovf_clr with a simultaneous non-fitting accept, set ovf_count to 1; ovf_clr alone sets 0.
REQ-028 SHALL ignore in_data and in_sat when no accept occurs.

Reset
REQ-029 SHALL, on rst=1, go to EMPTY and set out_valid=0, in_ready=0 during the reset cycle, out_data=0, out_fits=0, ovf_count=0.
REQ-030 SHALL discard any buffered items when rst asserts mid-operation, and SHALL ignore an accept presented in that cycle.
REQ-031 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-032 SHALL give rst priority over ovf_clr and all handshakes.

Verification
REQ-033 SHALL verify in_data=16'h0008, in_sat=1 -> out_data=4'b0111, out_fits=0, ovf_count 0->1; the same value with in_sat=0 -> out_data=4'b1000, out_fits=0.
REQ-034 SHALL verify 16'hFFF8 -> 4'b1000, fits=1; 16'h0007 -> 4'b0111, fits=1; 16'h8000 with in_sat=1 -> 4'b1000, fits=0.
REQ-035 SHALL verify backpressure: out_ready=0 with 3 offered items -> in_ready falls after 2 accepts; releasing out_ready drains the items in order with outputs held stable while stalled.
REQ-036 SHALL verify a 300-item non-fitting stream -> ovf_count=255; ovf_clr together with a non-fitting accept -> ovf_count=1.
REQ-037 SHALL verify rst asserted while in TWO -> next cycle out_valid=0 and ovf_count=0, with no stale item emitted afterwards.
REQ-038 SHALL verify continuous streaming with out_ready=1 -> one result per cycle, latency 1, state stays ONE.
